l1_pmem_arbiter: RTL and testbench
==================================

Name: l1_pmem_arbiter

Overview:
- Responder for the L1 caches' line-fill port (`pmem_address` out, 256-bit `pmem_rdata` in, plus resp).
- Accepts line requests from the L1I cache (read-only) and the L1D cache (read/write).
- Serialises them onto a single downstream L2/physical-memory port.
- Registers each granted request and returns the fetched line with a one-cycle resp pulse.

Parameters:
- ADDR_W, 32, byte address width; line-aligned addresses carry 5 zero LSBs.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_pmem_read  in  1  L1I line-read request, held until i_pmem_resp.
- i_pmem_address  in  ADDR_W  L1I line address.
- i_pmem_rdata  out  LINE_W  line returned to L1I.
- i_pmem_resp  out  1  one-cycle completion pulse to L1I.
- d_pmem_read  in  1  L1D line-read request.
- d_pmem_write  in  1  L1D line-writeback request.
- d_pmem_address  in  ADDR_W  L1D line address.
- d_pmem_wdata  in  LINE_W  L1D writeback data.
- d_pmem_rdata  out  LINE_W  line returned to L1D.
- d_pmem_resp  out  1  one-cycle completion pulse to L1D.
- l2_read  out  1  downstream read, held until l2_resp.
- l2_write  out  1  downstream write, held until l2_resp.
- l2_address  out  ADDR_W  downstream address.
- l2_wdata  out  LINE_W  downstream write data.
- l2_rdata  in  LINE_W  downstream read data, valid with l2_resp.
- l2_resp  in  1  downstream completion, one cycle.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=D.
  - All outputs 0: l2_read, l2_write, l2_address, l2_wdata, both rdata, both resp.
  - Asserting rst_n mid-transaction abandons it; no resp is issued, and a later stale l2_resp is ignored.
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
- IDLE, evaluated each cycle:
  - Requests are req_i=i_pmem_read and req_d=d_pmem_read|d_pmem_write.
  - Only req_i → SERVE_I. Only req_d → SERVE_D.
  - Both → round-robin: grant the side that is not last_grant. The first tie after reset therefore goes to I.
  - On grant, capture at the edge: address into l2_address, wdata (D only) into l2_wdata, and op type. Update last_grant.
  - l2_read/l2_write assert from the cycle after the request is first seen (registered outputs).
- SERVE_x:
  - Hold l2_read (or l2_write), l2_address and l2_wdata constant until l2_resp=1.
  - On l2_resp:
    - Deassert l2_read/l2_write at the next edge.
    - Capture l2_rdata into the granted side's rdata register.
    - Go to RESP_x.
  - Requester input changes while in SERVE are ignored; the captured copy is used.
- RESP_x:
  - x_pmem_resp=1 for exactly this cycle, then → IDLE.
  - The requester drops its request in response, so IDLE never re-grants the completed request.
  - For writebacks, d_pmem_rdata is not updated; only resp pulses.
- x_pmem_rdata holds its value until the next completed read for that side.
- Minimum latency, request at cycle t with l2_resp at the first opportunity:
  - l2_read high at t+1.
  - l2_resp at t+1 gives x_pmem_resp at t+2.
  - Next grant is evaluated at t+3.
- Illegal d_pmem_read & d_pmem_write both high: treated as a write.
- l2_resp while in IDLE or RESP_x is ignored.
- Only one downstream transaction is ever outstanding; l2_read and l2_write are never high together.

Decomposition:
- Shared package cache_pkg:
  - typedef enum arb_state_t {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D}.
  - typedef enum grant_t {GRANT_I, GRANT_D}.
  - Constants LINE_W=256, OFFSET_W=5.
- No sub-module is warranted; reuse the existing parameterised register cell for the 256-bit rdata holding registers.

Test Plan:
- Single I read: i_pmem_read at t, addr 0x0000_1A20, l2_resp with line 0xDEAD…BEEF at t+3 → l2_read high t+1..t+3 with l2_address=0x1A20; i_pmem_resp=1 only at t+4; i_pmem_rdata=line.
- D writeback: d_pmem_write, addr 0x40, wdata all-0xA5 → l2_write held with l2_wdata=0xA5…; d_pmem_resp one pulse; d_pmem_rdata unchanged.
- Simultaneous I and D reads right after reset → I served first, D granted the cycle after I's RESP; a second tie goes to I again only if D was served last.
- Requester changes address mid-SERVE (0x100→0x200) → l2_address stays 0x100 until l2_resp.
- rst_n pulled low during SERVE_D, then released, then a late l2_resp → all outputs 0, no d_pmem_resp, state IDLE.
- Spurious l2_resp in IDLE → no resp pulse and no rdata change.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the L1 line-fill arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which L1 side owns the downstream port
//   LINE_W      : cache line width in bits
//   OFFSET_W    : byte-offset bits within a line (line addresses have these LSBs zero)
package cache_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/l1_pmem_arbiter_if.sv
// Line-fill memory port: one requester (master) and one responder (slave).
//   read / write : request type, held by the master until resp
//   address      : line address
//   wdata        : writeback line
//   rdata        : returned line, valid with resp
//   resp         : one-cycle completion pulse from the slave
interface l1_pmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (
    output read,
    output write,
    output address,
    output wdata,
    input  rdata,
    input  resp
  );

  modport slave (
    input  read,
    input  write,
    input  address,
    input  wdata,
    output rdata,
    output resp
  );

endinterface

// File: rtl/l1_pmem_arbiter_reg.sv
// Parameterised load-enable register with async active-low clear.
//   clk, rst_n : clock and async reset (clears q to zero)
//   en         : load d into q at the rising edge
//   d, q       : W-bit data in / held value out
module l1_pmem_arbiter_reg #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/l1_pmem_arbiter.sv
// Arbiter between the L1I (read-only) and L1D (read/write) line-fill ports and
// a single downstream L2 port. One downstream transaction at a time; ties are
// broken round-robin. Every downstream output is registered.
//   clk, rst_n : clock, async active-low reset
//   i_bus      : L1I port (slave side; write/wdata are ignored)
//   d_bus      : L1D port (slave side)
//   l2_bus     : downstream port (master side)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction; arbitrate between pending I and D requests
// SERVE_I | L1I read outstanding downstream, waiting for l2 resp
// SERVE_D | L1D read or writeback outstanding downstream
// RESP_I  | one-cycle resp pulse to L1I; line already in i rdata register
// RESP_D  | one-cycle resp pulse to L1D; rdata updated only for reads
module l1_pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = cache_pkg::LINE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  l1_pmem_arbiter_if.slave         i_bus,
  l1_pmem_arbiter_if.slave         d_bus,
  l1_pmem_arbiter_if.master        l2_bus
);

  import cache_pkg::*;

  arb_state_t        state_q, state_d;
  grant_t            last_q, last_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              ld_i, ld_d;
  logic              req_i, req_d, pick_i;

  // The L1I port never writes.
  logic unused_i_side;
  assign unused_i_side = ^{i_bus.write, i_bus.wdata};

  assign req_i  = i_bus.read;
  assign req_d  = d_bus.read | d_bus.write;
  // I wins when it is the only requester or when D had the previous grant.
  assign pick_i = req_i && (!req_d || (last_q == GRANT_D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= GRANT_D;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ld_i    = 1'b0;
    ld_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d = SERVE_I;
          last_d  = GRANT_I;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          addr_d  = i_bus.address;
        end else if (req_d) begin
          // read+write together is illegal; the write takes priority
          state_d = SERVE_D;
          last_d  = GRANT_D;
          rd_d    = ~d_bus.write;
          wr_d    = d_bus.write;
          addr_d  = d_bus.address;
          wdata_d = d_bus.wdata;
        end
      end
      SERVE_I: begin
        if (l2_bus.resp) begin
          state_d = RESP_I;
          rd_d    = 1'b0;
          ld_i    = 1'b1;
        end
      end
      SERVE_D: begin
        if (l2_bus.resp) begin
          state_d = RESP_D;
          ld_d    = rd_q;     // writebacks leave d rdata untouched
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      RESP_I, RESP_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  l1_pmem_arbiter_reg #(.W(LINE_W)) u_i_rdata (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ld_i),
    .d     (l2_bus.rdata),
    .q     (i_bus.rdata)
  );

  l1_pmem_arbiter_reg #(.W(LINE_W)) u_d_rdata (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ld_d),
    .d     (l2_bus.rdata),
    .q     (d_bus.rdata)
  );

  assign i_bus.resp     = (state_q == RESP_I);
  assign d_bus.resp     = (state_q == RESP_D);
  assign l2_bus.read    = rd_q;
  assign l2_bus.write   = wr_q;
  assign l2_bus.address = addr_q;
  assign l2_bus.wdata   = wdata_q;

endmodule

// File: tb/tb_l1_pmem_arbiter.sv
module tb_l1_pmem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  localparam logic [LW-1:0] LINE1 = {8{32'hDEAD_BEEF}};
  localparam logic [LW-1:0] LA    = {8{32'hA1A1_0001}};
  localparam logic [LW-1:0] LB    = {8{32'hB2B2_0002}};
  localparam logic [LW-1:0] LC    = {8{32'hC3C3_0003}};
  localparam logic [LW-1:0] LD    = {8{32'hD4D4_0004}};
  localparam logic [LW-1:0] LE    = {8{32'hE5E5_0005}};
  localparam logic [LW-1:0] LF    = {8{32'hF6F6_0006}};
  localparam logic [LW-1:0] LG    = {8{32'h1717_0007}};
  localparam logic [LW-1:0] LH    = {8{32'h2828_0008}};
  localparam logic [LW-1:0] JUNK  = {8{32'h0BAD_F00D}};
  localparam logic [LW-1:0] WB_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] WB_5A = {32{8'h5A}};

  logic clk = 1'b0;
  logic rst_n;

  l1_pmem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) i_bus ();
  l1_pmem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) d_bus ();
  l1_pmem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) l2_bus ();

  l1_pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_bus  (i_bus),
    .d_bus  (d_bus),
    .l2_bus (l2_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            side_d;
    logic [LW-1:0] line;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic void check(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void expect_resp(bit side_d, logic [LW-1:0] line);
    exp_t e;
    e.side_d = side_d;
    e.line   = line;
    exp_q.push_back(e);
  endfunction

  // Monitor: every resp pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (l2_bus.read || l2_bus.write)
      check("l2_one_op", LW'(l2_bus.read & l2_bus.write), '0);
    if (i_bus.resp || d_bus.resp) begin
      check("resp_exclusive", LW'(i_bus.resp & d_bus.resp), '0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected none", i_bus.resp, d_bus.resp);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_side", LW'(d_bus.resp), LW'(mon_e.side_d));
        check("resp_rdata", mon_e.side_d ? d_bus.rdata : i_bus.rdata, mon_e.line);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(string nm);
    check({nm, "_l2_read"},  LW'(l2_bus.read),    '0);
    check({nm, "_l2_write"}, LW'(l2_bus.write),   '0);
    check({nm, "_l2_addr"},  LW'(l2_bus.address), '0);
    check({nm, "_l2_wdata"}, l2_bus.wdata,        '0);
    check({nm, "_i_rdata"},  i_bus.rdata,         '0);
    check({nm, "_d_rdata"},  d_bus.rdata,         '0);
    check({nm, "_i_resp"},   LW'(i_bus.resp),     '0);
    check({nm, "_d_resp"},   LW'(d_bus.resp),     '0);
  endtask

  // Wait for the downstream request, check it, hold it for 'hold' cycles,
  // then answer with 'line'. Returns at the negedge of the resp-pulse cycle.
  task automatic do_serve(input string nm, input logic [AW-1:0] addr, input bit wr,
                          input logic [LW-1:0] wd, input logic [LW-1:0] line,
                          input int hold, input int exp_lat, input bit scramble);
    int n = 0;
    tick();
    while (!(l2_bus.read || l2_bus.write) && n < 8) begin
      tick();
      n++;
    end
    if (n >= 8) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_grant_timeout: got no l2 request expected one within 8 cycles", nm);
      return;
    end
    if (exp_lat >= 0) check({nm, "_latency"}, LW'(n), LW'(exp_lat));
    check({nm, "_addr"}, LW'(l2_bus.address), LW'(addr));
    check({nm, "_op"}, LW'({l2_bus.write, l2_bus.read}), wr ? LW'(2'b10) : LW'(2'b01));
    if (wr) check({nm, "_wdata"}, l2_bus.wdata, wd);
    if (scramble) begin
      d_bus.address = addr + 32'h100;
      d_bus.wdata   = ~d_bus.wdata;
      i_bus.address = addr ^ 32'h0000_0F00;
    end
    for (int k = 0; k < hold; k++) begin
      tick();
      check({nm, "_hold_addr"}, LW'(l2_bus.address), LW'(addr));
      check({nm, "_hold_op"}, LW'({l2_bus.write, l2_bus.read}), wr ? LW'(2'b10) : LW'(2'b01));
      if (wr) check({nm, "_hold_wdata"}, l2_bus.wdata, wd);
    end
    l2_bus.rdata = line;
    l2_bus.resp  = 1'b1;
    tick();
    l2_bus.resp  = 1'b0;
    l2_bus.rdata = ~line;
    check({nm, "_drop"}, LW'({l2_bus.write, l2_bus.read}), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b1;
    i_bus.read     = 1'b0;
    i_bus.write    = 1'b0;
    i_bus.address  = '0;
    i_bus.wdata    = '0;
    d_bus.read     = 1'b0;
    d_bus.write    = 1'b0;
    d_bus.address  = '0;
    d_bus.wdata    = '0;
    l2_bus.rdata   = '0;
    l2_bus.resp    = 1'b0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // First tie after reset goes to I; D follows right after I's resp cycle.
    expect_resp(1'b0, LA);
    expect_resp(1'b1, LB);
    i_bus.read = 1'b1; i_bus.address = 32'h0000_2000;
    d_bus.read = 1'b1; d_bus.address = 32'h0000_3000;
    do_serve("tie1_i", 32'h0000_2000, 1'b0, '0, LA, 0, 0, 1'b0);
    i_bus.read = 1'b0;
    do_serve("tie1_d", 32'h0000_3000, 1'b0, '0, LB, 0, 1, 1'b0);
    d_bus.read = 1'b0;
    tick();

    // D served last: next tie goes to I.
    expect_resp(1'b0, LC);
    expect_resp(1'b1, LD);
    i_bus.read = 1'b1; i_bus.address = 32'h0000_4000;
    d_bus.read = 1'b1; d_bus.address = 32'h0000_5000;
    do_serve("tie2_i", 32'h0000_4000, 1'b0, '0, LC, 0, 0, 1'b0);
    i_bus.read = 1'b0;
    do_serve("tie2_d", 32'h0000_5000, 1'b0, '0, LD, 0, 1, 1'b0);
    d_bus.read = 1'b0;
    tick();

    // Single I read, l2_resp three cycles after the request.
    expect_resp(1'b0, LINE1);
    i_bus.read = 1'b1; i_bus.address = 32'h0000_1A20;
    do_serve("i_read", 32'h0000_1A20, 1'b0, '0, LINE1, 2, 0, 1'b0);
    i_bus.read = 1'b0;
    tick();
    check("i_resp_one_pulse", LW'(i_bus.resp), '0);
    check("i_rdata_held", i_bus.rdata, LINE1);

    // I served last: a tie now goes to D.
    expect_resp(1'b1, LE);
    expect_resp(1'b0, LF);
    i_bus.read = 1'b1; i_bus.address = 32'h0000_6000;
    d_bus.read = 1'b1; d_bus.address = 32'h0000_7000;
    do_serve("tie3_d", 32'h0000_7000, 1'b0, '0, LE, 0, 0, 1'b0);
    d_bus.read = 1'b0;
    do_serve("tie3_i", 32'h0000_6000, 1'b0, '0, LF, 0, 1, 1'b0);
    i_bus.read = 1'b0;
    tick();

    // Writeback: d rdata keeps the last read line.
    expect_resp(1'b1, LE);
    d_bus.write = 1'b1; d_bus.address = 32'h0000_0040; d_bus.wdata = WB_A5;
    do_serve("wb", 32'h0000_0040, 1'b1, WB_A5, JUNK, 1, 0, 1'b0);
    d_bus.write = 1'b0;
    tick();
    check("wb_d_rdata_kept", d_bus.rdata, LE);

    // Illegal read+write is a write.
    expect_resp(1'b1, LE);
    d_bus.read = 1'b1; d_bus.write = 1'b1; d_bus.address = 32'h0000_0080; d_bus.wdata = WB_5A;
    do_serve("rdwr", 32'h0000_0080, 1'b1, WB_5A, JUNK, 0, 0, 1'b0);
    d_bus.read = 1'b0; d_bus.write = 1'b0;
    tick();

    // Requester moves its address mid-serve; captured 0x100 must stay.
    expect_resp(1'b1, LG);
    d_bus.read = 1'b1; d_bus.address = 32'h0000_0100;
    do_serve("addr_chg", 32'h0000_0100, 1'b0, '0, LG, 3, 0, 1'b1);
    d_bus.read = 1'b0; d_bus.address = '0; i_bus.address = '0;
    tick();

    // Spurious l2_resp in IDLE.
    l2_bus.rdata = JUNK;
    l2_bus.resp  = 1'b1;
    tick();
    l2_bus.resp  = 1'b0;
    tick();
    tick();
    check("spur_i_rdata", i_bus.rdata, LF);
    check("spur_d_rdata", d_bus.rdata, LG);
    check("spur_i_resp", LW'(i_bus.resp), '0);
    check("spur_d_resp", LW'(d_bus.resp), '0);
    check("spur_l2_op", LW'({l2_bus.write, l2_bus.read}), '0);

    // Reset during SERVE_D, then a stale l2_resp.
    d_bus.read = 1'b1; d_bus.address = 32'h0000_0600;
    tick();
    check("abort_started", LW'(l2_bus.read), LW'(1'b1));
    check("abort_addr", LW'(l2_bus.address), LW'(32'h0000_0600));
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_in_rst");
    d_bus.read = 1'b0; d_bus.address = '0;
    tick();
    rst_n = 1'b1;
    l2_bus.rdata = JUNK;
    l2_bus.resp  = 1'b1;
    tick();
    l2_bus.resp  = 1'b0;
    tick();
    check_all_zero("abort_after");

    // Arbiter is back in IDLE: a fresh I read is granted at once.
    expect_resp(1'b0, LH);
    i_bus.read = 1'b1; i_bus.address = 32'h0000_0800;
    do_serve("post_rst", 32'h0000_0800, 1'b0, '0, LH, 0, 0, 1'b0);
    i_bus.read = 1'b0;
    tick();
    tick();

    check("queue_empty", LW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
